// File: rtl/out_hex_uart_if.sv
// Producer-side word handshake for out_hex_uart.
//   out_valid : producer presents a word (CPU OUT instruction)
//   out_data  : 16-bit word to print
//   out_ready : consumer can accept a word this cycle
// master = producer (CPU), slave = out_hex_uart.
interface out_hex_uart_if;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/out_hex_uart.sv
// out_hex_uart: buffers 16-bit words in a small FIFO and prints each one on an
// 8N1 UART line as four lowercase hex digits followed by a newline (0x0A).
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high reset
//   out_if   : word handshake (slave side); out_ready depends on registered count only
//   tx       : UART serial output, idle high, driven straight from a flop
//   busy     : FIFO non-empty or a character in flight
//   overflow : sticky, set when a presented word had to be dropped
module out_hex_uart #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          reset,
    out_hex_uart_if.slave out_if,
    output logic          tx,
    output logic          busy,
    output logic          overflow
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudMax  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [PtrW:0]   FifoFull = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            fifo_ready;
    logic            push;
    logic            pop;
    logic [15:0]     head;

    // Ready comes from the registered count alone, so a pop on a full cycle
    // does not open the door until the next cycle.
    assign fifo_ready       = (count_q < FifoFull);
    assign out_if.out_ready = fifo_ready;
    assign push             = out_if.out_valid & fifo_ready;
    assign head             = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (out_if.out_valid && !fifo_ready) begin
            overflow_d = 1'b1;
        end
    end

    // Storage is not reset; only pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= out_if.out_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Hex formatter and UART transmitter
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [15:0]     hold_q, hold_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic            tx_q, tx_d;
    logic            baud_done;
    logic [3:0]      nibble;
    logic [7:0]      char_byte;

    assign baud_done = (baud_q == BaudMax);

    always_comb begin
        nibble = 4'h0;
        unique case (idx_q)
            3'd0:    nibble = hold_q[15:12];
            3'd1:    nibble = hold_q[11:8];
            3'd2:    nibble = hold_q[7:4];
            3'd3:    nibble = hold_q[3:0];
            default: nibble = 4'h0;
        endcase
        if (idx_q == 3'd4) begin
            char_byte = 8'h0a;
        end else if (nibble < 4'd10) begin
            char_byte = 8'h30 + {4'h0, nibble};
        end else begin
            // 'a' - 10 = 0x57, keeps digits a-f lowercase.
            char_byte = 8'h57 + {4'h0, nibble};
        end
    end

    // tx_d is computed alongside the state so tx changes on the very edge
    // that enters each bit period, and stays a pure flop output.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    hold_d  = head;
                    idx_d   = 3'd0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shift_d = char_byte;
                baud_d  = '0;
                tx_d    = 1'b0;
                state_d = StStart;
            end
            StStart: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StStop: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (idx_q < 3'd4) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            hold_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != StIdle) || (count_q != '0);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_out_hex_uart.sv
// Self-checking bench for out_hex_uart (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// Accepted words are expanded into their "%h\n" text on a byte queue; a UART
// monitor decodes tx and pops/compares each received byte.
module tb_out_hex_uart;

    localparam int C = 4;
    localparam int Depth = 8;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic busy;
    logic overflow;

    out_hex_uart_if u_if ();

    out_hex_uart #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (Depth)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .out_if  (u_if.slave),
        .tx      (tx),
        .busy    (busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int n_bytes = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [15:0] w);
        string s;
        s = $sformatf("%h\n", w);
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back(s[i]);
        end
    endtask

    // Called on a negedge; presents w across one rising edge.
    task automatic push(input logic [15:0] w, input bit exp_acc);
        u_if.out_valid = 1'b1;
        u_if.out_data  = w;
        check("out_ready", {31'b0, u_if.out_ready}, {31'b0, exp_acc});
        if (exp_acc) begin
            sb_push(w);
        end
        @(negedge clk);
        u_if.out_valid = 1'b0;
    endtask

    // Negedges until busy drops, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        wait_idle(n);
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    // UART monitor: a start is seen on the first negedge with tx low; each bit
    // is sampled in the middle of its period.
    logic [7:0] mon_byte;
    logic mon_start;
    logic mon_stop;
    bit mon_abort;
    int mon_slot;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                mon_abort = 1'b0;
                mon_byte  = 8'h00;
                mon_start = 1'b1;
                mon_stop  = 1'b0;
                for (int k = 1; k <= 9 * C + C / 2; k++) begin
                    @(negedge clk);
                    if (reset) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    if (k >= C / 2 && ((k - C / 2) % C) == 0) begin
                        mon_slot = (k - C / 2) / C;
                        if (mon_slot == 0) mon_start = tx;
                        else if (mon_slot <= 8) mon_byte[mon_slot-1] = tx;
                        else mon_stop = tx;
                    end
                end
                if (!mon_abort) begin
                    n_bytes++;
                    check("start_bit", {31'b0, mon_start}, 32'd0);
                    check("stop_bit", {31'b0, mon_stop}, 32'd1);
                    check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        check("tx_byte", {24'b0, mon_byte}, {24'b0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : main
        int n;
        int bytes_at_reset;
        u_if.out_valid = 1'b0;
        u_if.out_data  = 16'h0000;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_ready", {31'b0, u_if.out_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single word; busy spans the IDLE pop cycle plus five 41-cycle frames
        // counted from the push edge.
        push(16'h12ab, 1'b1);
        wait_idle(n);
        check("busy_fall_single", n, 32'd206);
        check("single_sb_empty", exp_q.size(), 32'd0);
        @(negedge clk);

        // Back to back: busy never drops, so no gap beyond the IDLE pop cycle.
        push(16'h0000, 1'b1);
        push(16'hffff, 1'b1);
        wait_idle(n);
        check("busy_fall_pair", n, 32'd411);
        check("pair_sb_empty", exp_q.size(), 32'd0);
        @(negedge clk);

        // Ten pushes from idle: first is popped at once, eight fill the FIFO,
        // the tenth is dropped.
        for (int i = 1; i <= 10; i++) begin
            push(16'(i), i <= 9);
        end
        check("ovf_set", {31'b0, overflow}, 32'd1);
        drain("ovf");
        check("ovf_sticky", {31'b0, overflow}, 32'd1);

        reset = 1'b1;
        #1;
        check("rst2_overflow", {31'b0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Fill the FIFO, then present a word on the exact cycle of the next pop.
        for (int i = 0; i < 9; i++) begin
            push(16'h0101 + 16'(i), 1'b1);
        end
        check("full_no_ovf", {31'b0, overflow}, 32'd0);
        repeat (198) @(negedge clk);
        push(16'h0bad, 1'b0);
        check("popcyc_ovf", {31'b0, overflow}, 32'd1);
        push(16'h0c0d, 1'b1);
        drain("popcyc");

        // Random bursts of at most FIFO_DEPTH words from an empty FIFO.
        for (int b = 0; b < 6; b++) begin
            int nw;
            nw = $urandom_range(1, Depth);
            for (int i = 0; i < nw; i++) begin
                push(16'($urandom), 1'b1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            drain("rand");
        end

        // Reset during data bit 3 of the second character ('a' = 0x61).
        push(16'h5a5a, 1'b1);
        repeat (60) @(negedge clk);
        check("pre_rst_tx_bit3", {31'b0, tx}, 32'd0);
        bytes_at_reset = n_bytes;
        reset = 1'b1;
        #1;
        check("midrst_tx", {31'b0, tx}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_ready", {31'b0, u_if.out_ready}, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        repeat (300) @(negedge clk);
        check("postrst_bytes", n_bytes, bytes_at_reset);
        check("postrst_busy", {31'b0, busy}, 32'd0);
        check("postrst_tx", {31'b0, tx}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/out_hex_uart.md
OUT_HEX_UART -- requirements
Module: out_hex_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, word buffer entries (power of two, minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; all state is updated on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port out_valid  input  1  producer presents a word; driven by the CPU OUT instruction (opcode 0x77).
REQ-006 SHALL have port out_data  input  16  word to print (the CPU AC value).
REQ-007 SHALL have port out_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-009 SHALL have port busy  output  1  FIFO non-empty or a character is being sent.
REQ-010 SHALL have port overflow  output  1  sticky flag: a word was dropped.

Function
REQ-011 SHALL accept a word into the FIFO on every rising edge where out_valid=1 and out_ready=1.
REQ-012 SHALL drive out_ready = (FIFO count < FIFO_DEPTH), decoded from registered count only, with no combinational path from out_valid.
REQ-013 SHALL drop the word and set overflow=1 when out_valid=1 and out_ready=0; overflow SHALL remain 1 until reset.
REQ-014 SHALL, on a cycle where the FIFO is full and a pop occurs, still reject any word presented that cycle (out_ready=0); out_ready SHALL rise on the following cycle.
REQ-015 SHALL, when the FIFO is empty and a push occurs, update the count in the same edge; a simultaneous push and pop SHALL leave the count unchanged.
REQ-016 SHALL use wrap-around read and write pointers of log2(FIFO_DEPTH) bits plus a count of log2(FIFO_DEPTH)+1 bits.
REQ-017 SHALL implement FSM states IDLE, LOAD, START, DATA, STOP.
REQ-018 SHALL, in IDLE with the FIFO non-empty, pop the head word into a 16-bit holding register, set char index=0, and enter LOAD.
REQ-019 SHALL, in LOAD, form the character byte for the current index: indices 0..3 = nibbles [15:12], [11:8], [7:4], [3:0]; index 4 = 0x0A.
REQ-020 SHALL encode nibble 0-9 as 0x30-0x39 and nibble a-f as lowercase 0x61-0x66, then enter START.
REQ-021 SHALL, in START, drive tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-022 SHALL, in DATA, drive 8 bits LSB first, each for exactly CLKS_PER_BIT cycles, then enter STOP.
REQ-023 SHALL, in STOP, drive tx=1 for CLKS_PER_BIT cycles, then go to LOAD with index+1 if index<4, otherwise to IDLE.
REQ-024 SHALL hold tx=1 in IDLE and LOAD.
REQ-025 SHALL take one frame = 1 (LOAD) + 10*CLKS_PER_BIT cycles, and one word = 1 (IDLE pop) + 5*(1+10*CLKS_PER_BIT) cycles, measured from the pop edge until the return to IDLE.
REQ-026 SHALL drive busy = (state != IDLE) or (count != 0).
REQ-027 SHALL register tx directly from a flop, with no glitches.

Reset
REQ-028 SHALL, on reset=1 at any time (including mid-frame), immediately force tx=1, out_ready=1, busy=0, overflow=0, state=IDLE, count=0, and both pointers=0, aborting any partial character.
REQ-029 SHALL resume normal operation on the first rising clk edge after reset deasserts; FIFO contents are not required to be cleared.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-030 SHALL be verified with: single push 0x12ab -> tx carries bytes 0x31, 0x32, 0x61, 0x62, 0x0A, each with start=0 and stop=1, 4 cycles per bit; busy falls 1+5*41=206 cycles after the pop edge.
REQ-031 SHALL be verified with: push 0x0000 then 0xffff back to back -> bytes 30 30 30 30 0A 66 66 66 66 0A, with no idle gap beyond the 1-cycle IDLE pop between words.
REQ-032 SHALL be verified with: 10 consecutive pushes 0x0001..0x000a with tx idle -> first word popped, next 8 accepted; word 10 rejected (out_ready=0) and overflow=1; output shows 0x0001..0x0009 only; overflow stays 1.
REQ-033 SHALL be verified with: FIFO full, push attempted on the exact pop cycle -> word rejected, overflow=1, out_ready=1 on the next cycle, and a push then accepted.
REQ-034 SHALL be verified with: reset asserted during DATA bit 3 of the second character of 0x5a5a -> tx=1 within the same cycle (asynchronous), busy=0, and no further frames after release.
REQ-035 SHALL be verified with: random push bursts against a scoreboard of "%h\n"-formatted words -> decoded tx stream equals the accepted words in order.
